// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared definitions for the register-transaction sequencer: master command
// encodings, transaction/handshake state types and a small byte helper.
package i2c_reg_ctrl_pkg;

    // Command encodings understood by the i2c byte-level master
    localparam logic [2:0] k_START_CMD = 3'b001;
    localparam logic [2:0] k_WRITE_CMD = 3'b010;
    localparam logic [2:0] k_READ_CMD  = 3'b011;
    localparam logic [2:0] k_STOP_CMD  = 3'b100;

    localparam logic [15:0] k_CLOCK_DIVISOR  = 16'd5;
    localparam logic [19:0] k_TIMEOUT_CYCLES = 20'd100000;

    // Transaction-level states of the top FSM
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START1 = 4'd1,
        ST_ADDR_W = 4'd2,
        ST_REG    = 4'd3,
        ST_WDATA  = 4'd4,
        ST_RSTART = 4'd5,
        ST_ADDR_R = 4'd6,
        ST_READ   = 4'd7,
        ST_STOP   = 4'd8,
        ST_FIN    = 4'd9
    } txn_state_e;

    // Per-command handshake phases of the issuer
    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_ISSUE   = 2'd1,
        PH_WAIT_LO = 2'd2,
        PH_WAIT_HI = 2'd3
    } issue_phase_e;

    // Address byte on the bus: 7-bit device address followed by the R/W bit
    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
        return {dev, rd};
    endfunction

endpackage

// File: rtl/i2c_cmd_issuer.sv
// Runs one master command: waits for ready, strobes write with cmd/data_in,
// then waits for ready to drop and rise again. A watchdog aborts the command
// if the master does not complete it within TIMEOUT_CYCLES.
module i2c_cmd_issuer
    import i2c_reg_ctrl_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = k_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic [2:0] cmd_sel,
    input  logic [7:0] byte_sel,
    input  logic       ready,
    output logic [2:0] cmd,
    output logic [7:0] data_in,
    output logic       write,
    output logic       cmd_done,
    output logic       timed_out
);

    issue_phase_e phase_r;
    logic [19:0]  tmo_cnt_r;

    // Handshake sequencer and timeout counter; cmd/data_in held until the next issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r   <= PH_IDLE;
            tmo_cnt_r <= 20'd0;
            cmd       <= k_STOP_CMD;
            data_in   <= 8'd0;
            write     <= 1'b0;
            cmd_done  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            write     <= 1'b0;
            cmd_done  <= 1'b0;
            timed_out <= 1'b0;
            case (phase_r)
                PH_IDLE: begin
                    if (go) begin
                        phase_r <= PH_ISSUE;
                    end
                end
                PH_ISSUE: begin
                    if (ready) begin
                        cmd       <= cmd_sel;
                        data_in   <= byte_sel;
                        write     <= 1'b1;
                        tmo_cnt_r <= 20'd0;
                        phase_r   <= PH_WAIT_LO;
                    end
                end
                PH_WAIT_LO: begin
                    if (tmo_cnt_r == TIMEOUT_CYCLES - 20'd1) begin
                        timed_out <= 1'b1;
                        phase_r   <= PH_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 20'd1;
                        if (!ready) begin
                            phase_r <= PH_WAIT_HI;
                        end
                    end
                end
                PH_WAIT_HI: begin
                    if (tmo_cnt_r == TIMEOUT_CYCLES - 20'd1) begin
                        timed_out <= 1'b1;
                        phase_r   <= PH_IDLE;
                    end else if (ready) begin
                        cmd_done <= 1'b1;
                        phase_r  <= PH_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 20'd1;
                    end
                end
                default: begin
                    phase_r <= PH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-transaction sequencer: expands a single register read or write
// request into the START/WRITE/READ/STOP command stream of the i2c master
// and reports read data, NACK and timeout status with a one-cycle done pulse.
module i2c_reg_ctrl
    import i2c_reg_ctrl_pkg::*;
#(
    parameter logic [15:0] CLOCK_DIVISOR  = k_CLOCK_DIVISOR,
    parameter logic [19:0] TIMEOUT_CYCLES = k_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rnw,
    input  logic [6:0]  dev_addr,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        nack_err,
    output logic        timeout_err,
    output logic [15:0] clock_divisor,
    output logic [2:0]  cmd,
    output logic [7:0]  data_in,
    output logic        write,
    input  logic        ready,
    input  logic [7:0]  data_out,
    input  logic        ack
);

    txn_state_e state_r;
    logic       rnw_r;
    logic [6:0] dev_r;
    logic [7:0] reg_r;
    logic [7:0] wdat_r;
    logic       go_r;
    logic [2:0] cmd_sel_s;
    logic [7:0] byte_sel_s;
    logic       cmd_done_s;
    logic       timed_out_s;

    assign clock_divisor = CLOCK_DIVISOR;

    // Command and byte the current state asks the master to perform
    always_comb begin
        cmd_sel_s  = k_STOP_CMD;
        byte_sel_s = 8'd0;
        case (state_r)
            ST_START1, ST_RSTART: cmd_sel_s = k_START_CMD;
            ST_ADDR_W: begin
                cmd_sel_s  = k_WRITE_CMD;
                byte_sel_s = addr_byte(dev_r, 1'b0);
            end
            ST_REG: begin
                cmd_sel_s  = k_WRITE_CMD;
                byte_sel_s = reg_r;
            end
            ST_WDATA: begin
                cmd_sel_s  = k_WRITE_CMD;
                byte_sel_s = wdat_r;
            end
            ST_ADDR_R: begin
                cmd_sel_s  = k_WRITE_CMD;
                byte_sel_s = addr_byte(dev_r, 1'b1);
            end
            ST_READ: cmd_sel_s = k_READ_CMD;
            default: begin
                cmd_sel_s  = k_STOP_CMD;
                byte_sel_s = 8'd0;
            end
        endcase
    end

    // Transaction FSM: request capture, command sequencing and status reporting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rnw_r       <= 1'b0;
            dev_r       <= 7'd0;
            reg_r       <= 8'd0;
            wdat_r      <= 8'd0;
            go_r        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_data     <= 8'd0;
            nack_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            go_r <= 1'b0;
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        rnw_r       <= rnw;
                        dev_r       <= dev_addr;
                        reg_r       <= reg_addr;
                        wdat_r      <= wr_data;
                        busy        <= 1'b1;
                        nack_err    <= 1'b0;
                        timeout_err <= 1'b0;
                        go_r        <= 1'b1;
                        state_r     <= ST_START1;
                    end
                end
                ST_START1, ST_ADDR_W, ST_REG, ST_WDATA,
                ST_RSTART, ST_ADDR_R, ST_READ, ST_STOP: begin
                    if (timed_out_s) begin
                        // Abort without a STOP: the master is not answering
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_r     <= ST_FIN;
                    end else if (cmd_done_s) begin
                        go_r <= (state_r != ST_STOP);
                        case (state_r)
                            ST_START1: state_r <= ST_ADDR_W;
                            ST_ADDR_W: begin
                                nack_err <= ack;
                                state_r  <= ack ? ST_STOP : ST_REG;
                            end
                            ST_REG: begin
                                nack_err <= ack;
                                if (ack) begin
                                    state_r <= ST_STOP;
                                end else begin
                                    state_r <= rnw_r ? ST_RSTART : ST_WDATA;
                                end
                            end
                            ST_WDATA: begin
                                nack_err <= ack;
                                state_r  <= ST_STOP;
                            end
                            ST_RSTART: state_r <= ST_ADDR_R;
                            ST_ADDR_R: begin
                                nack_err <= ack;
                                state_r  <= ack ? ST_STOP : ST_READ;
                            end
                            ST_READ: begin
                                rd_data <= data_out;
                                state_r <= ST_STOP;
                            end
                            ST_STOP: begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_r <= ST_FIN;
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    i2c_cmd_issuer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_issuer (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (go_r),
        .cmd_sel  (cmd_sel_s),
        .byte_sel (byte_sel_s),
        .ready    (ready),
        .cmd      (cmd),
        .data_in  (data_in),
        .write    (write),
        .cmd_done (cmd_done_s),
        .timed_out(timed_out_s)
    );

endmodule
